// File: rtl/cp0_regs_pkg.sv
// Shared definitions for the CP0 register block.
//   - cp0_regfile_t : packed snapshot of every implemented CP0 register
//   - RS_*          : mtc0 register-select codes (0 means "no write")
//   - EXC_*         : ExcCode values
//   - STATUS_* / CAUSE_* : bit positions inside Status and Cause
package cp0_regs_pkg;

    // mtc0 select codes use the architectural register numbers.
    localparam logic [7:0] RS_NONE     = 8'd0;
    localparam logic [7:0] RS_BADVADDR = 8'd8;
    localparam logic [7:0] RS_COUNT    = 8'd9;
    localparam logic [7:0] RS_COMPARE  = 8'd11;
    localparam logic [7:0] RS_STATUS   = 8'd12;
    localparam logic [7:0] RS_CAUSE    = 8'd13;
    localparam logic [7:0] RS_EPC      = 8'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_BEV   = 22;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IE    = 0;

    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_CODE_HI = 6;
    localparam int CAUSE_CODE_LO = 2;

    // BEV is hard-wired to 1; everything else in Status resets to 0.
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] badvaddr;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
    } cp0_regfile_t;

endpackage

// File: rtl/cp0_regs_timer.sv
// Count/Compare timer for CP0.
//   clk, reset      : clock, async active-high reset
//   count_we        : load Count from wdata (also restarts the divider tick)
//   compare_we      : load Compare from wdata (also clears TI)
//   wdata           : write data
//   count, compare  : current register values
//   ti              : timer interrupt, set the cycle after Count==Compare
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam bit DIV_ONE = (COUNT_DIV == 1);

    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        tick_reg;
    logic        ti_reg;
    logic        count_inc;

    // With a divide-by-2 the tick marks every second cycle; divide-by-1 ignores it.
    assign count_inc = DIV_ONE | tick_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg   <= '0;
            compare_reg <= '0;
            tick_reg    <= 1'b0;
            ti_reg      <= 1'b0;
        end else begin
            if (count_we) begin
                count_reg <= wdata;
                tick_reg  <= 1'b0;
            end else begin
                tick_reg <= ~tick_reg;
                if (count_inc) begin
                    count_reg <= count_reg + 32'd1;
                end
            end
            // A Compare write clears TI even when the match fires that same cycle.
            if (compare_we) begin
                compare_reg <= wdata;
                ti_reg      <= 1'b0;
            end else if (count_reg == compare_reg) begin
                ti_reg <= 1'b1;
            end
        end
    end

    assign count   = count_reg;
    assign compare = compare_reg;
    assign ti      = ti_reg;
endmodule

// File: rtl/cp0_regs.sv
// CP0 system-control registers: Status, Cause, EPC, BadVAddr, Count, Compare.
//   clk, reset         : clock, async active-high reset
//   write_regsel/data  : mtc0 target select (0 = none) and data
//   write_PC, wfirst, wsecond : debug-only, not used by the logic
//   exc_*              : exception commit with its code, PC, delay-slot flag, bad address
//   eret               : eret commit
//   ext_int            : hardware interrupt lines (registered into Cause.IP[7:2])
//   cp0_reg            : current register values
//   int_pending        : enabled, unmasked interrupt present
//   cp0_flush          : flush request, redirect_pc is its target
module cp0_regs
    import cp0_regs_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   write_regsel,
    input  logic [31:0]  write_data,
    input  logic [31:0]  write_PC,
    input  logic         wfirst,
    input  logic         wsecond,
    input  logic         exc_valid,
    input  logic [4:0]   exc_code,
    input  logic [31:0]  exc_pc,
    input  logic         exc_bd,
    input  logic [31:0]  exc_badvaddr,
    input  logic         exc_badv_we,
    input  logic         eret,
    input  logic [5:0]   ext_int,
    output cp0_regfile_t cp0_reg,
    output logic         int_pending,
    output logic         cp0_flush,
    output logic [31:0]  redirect_pc
);
    logic [7:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic [4:0]  code_reg;
    logic [1:0]  ip_sw_reg;
    logic [5:0]  ext_int_reg;
    logic [31:0] epc_reg;
    logic [31:0] badvaddr_reg;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [7:0]  ip;
    logic [31:0] status_val;
    logic [31:0] cause_val;

    // Debug-only inputs are deliberately left unused.
    logic unused_debug;
    assign unused_debug = &{1'b0, write_PC, wfirst, wsecond};

    // An exception drops any same-cycle mtc0, including to the timer.
    logic mtc0_ok;
    assign mtc0_ok = ~exc_valid;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (mtc0_ok && (write_regsel == RS_COUNT)),
        .compare_we (mtc0_ok && (write_regsel == RS_COMPARE)),
        .wdata      (write_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_reg       <= '0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            code_reg     <= '0;
            ip_sw_reg    <= '0;
            ext_int_reg  <= '0;
            epc_reg      <= '0;
            badvaddr_reg <= '0;
        end else begin
            ext_int_reg <= ext_int;
            if (exc_valid) begin
                code_reg <= exc_code;
                exl_reg  <= 1'b1;
                // Nested exceptions keep the original return point.
                if (!exl_reg) begin
                    epc_reg <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
                    bd_reg  <= exc_bd;
                end
                if (exc_badv_we) begin
                    badvaddr_reg <= exc_badvaddr;
                end
            end else begin
                if (eret) begin
                    exl_reg <= 1'b0;
                end
                case (write_regsel)
                    RS_STATUS: begin
                        im_reg <= write_data[STATUS_IM_HI:STATUS_IM_LO];
                        ie_reg <= write_data[STATUS_IE];
                        // eret owns EXL in the cycle it commits.
                        if (!eret) begin
                            exl_reg <= write_data[STATUS_EXL];
                        end
                    end
                    RS_CAUSE: ip_sw_reg <= write_data[CAUSE_IP_LO+1:CAUSE_IP_LO];
                    RS_EPC:   epc_reg   <= write_data;
                    default:  ;
                endcase
            end
        end
    end

    // IP7 shares the timer interrupt with external line 5.
    assign ip = {ext_int_reg[5] | ti, ext_int_reg[4:0], ip_sw_reg};

    always_comb begin
        status_val = STATUS_RESET;
        status_val[STATUS_IM_HI:STATUS_IM_LO] = im_reg;
        status_val[STATUS_EXL] = exl_reg;
        status_val[STATUS_IE]  = ie_reg;
    end

    always_comb begin
        cause_val = '0;
        cause_val[CAUSE_BD] = bd_reg;
        cause_val[CAUSE_TI] = ti;
        cause_val[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
        cause_val[CAUSE_CODE_HI:CAUSE_CODE_LO] = code_reg;
    end

    assign cp0_reg.badvaddr = badvaddr_reg;
    assign cp0_reg.count    = count;
    assign cp0_reg.compare  = compare;
    assign cp0_reg.status   = status_val;
    assign cp0_reg.cause    = cause_val;
    assign cp0_reg.epc      = epc_reg;

    assign int_pending = ie_reg & ~exl_reg & (|(ip & im_reg));
    assign cp0_flush   = exc_valid | eret;
    assign redirect_pc = exc_valid ? EXC_VECTOR : epc_reg;
endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380, exception redirect target.
REQ-002 SHALL have parameter COUNT_DIV, default 2, cycles per Count increment (legal values 1 or 2).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports, in this order:
- clk  input  1  clock
- reset  input  1  async active-high reset
- write_regsel  input  8  mtc0 target; 0 = no write
- write_data  input  32  mtc0 data
- write_PC  input  32  PC of the mtc0
- wfirst  input  1  issue-slot flag, debug only
- wsecond  input  1  issue-slot flag, debug only
- exc_valid  input  1  exception commit
- exc_code  input  5  ExcCode
- exc_pc  input  32  faulting PC
- exc_bd  input  1  fault in delay slot
- exc_badvaddr  input  32  bad address
- exc_badv_we  input  1  load BadVAddr
- eret  input  1  eret commit
- ext_int  input  6  hardware interrupt lines
- cp0_reg  output  cp0_regfile_t  current register values
- int_pending  output  1  interrupt request
- cp0_flush  output  1  pipeline flush
- redirect_pc  output  32  flush target

Function
REQ-005 SHALL decode write_regsel against the shared RS_BADVADDR, RS_COUNT, RS_COMPARE, RS_STATUS, RS_CAUSE and RS_EPC constants; any other value SHALL be ignored.
REQ-006 SHALL apply all register updates on the rising clk edge, visible on cp0_reg the next cycle.
REQ-007 Write masks:
- Status: only IM[15:8], EXL[1] and IE[0] writable; BEV[22] reads 1; other bits 0.
- Cause: only IP[9:8] writable.
- BadVAddr: not writable by mtc0.
- Count, Compare, EPC: fully writable.
REQ-008 Count SHALL increment by 1, modulo 2^32, every COUNT_DIV cycles using an internal 1-bit tick; an mtc0 to Count SHALL load the value and restart the tick.
REQ-009 Cause.TI[30] SHALL be set the cycle after Count==Compare; it SHALL be cleared by an mtc0 to Compare, and the clear wins over a same-cycle set.
REQ-010 Cause.IP[15:10] SHALL equal registered {ext_int[5] | TI, ext_int[4:0]}.
REQ-011 int_pending SHALL be Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), combinational from registers.
REQ-012 On exc_valid:
- ExcCode is set to exc_code.
- EXL is set to 1.
- If EXL was 0: EPC = exc_bd ? exc_pc-4 : exc_pc, and BD = exc_bd.
- If EXL was 1: EPC and BD are unchanged.
- If exc_badv_we: BadVAddr = exc_badvaddr.
REQ-013 On eret without exc_valid, EXL SHALL be cleared.
REQ-014 cp0_flush SHALL be exc_valid | eret (combinational); redirect_pc SHALL be EXC_VECTOR on exc_valid, else EPC.
REQ-015 Same-cycle priority SHALL be exc_valid > eret > mtc0.
- With exc_valid, the mtc0 is dropped.
- With eret, an mtc0 to a register other than Status.EXL still takes effect.
REQ-016 Interrupt delivery to exc_valid SHALL be done upstream with ExcCode 0; this block performs no arbitration.

Reset
REQ-017 On reset:
- Status = 32'h0040_0000.
- Cause, Count, Compare, EPC, BadVAddr and the tick = 0.
- int_pending = 0.
- cp0_flush follows its inputs.
REQ-018 Reset asserted mid-operation SHALL override all same-cycle writes and exceptions.

Structure
REQ-019 cp0_regfile_t, the RS_* constants, the EXC_* codes and the Status/Cause bit-position constants SHALL live in the shared package header.
REQ-020 The Count/Compare timer SHALL be a sub-module, cp0_timer, outputting Count and TI.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then 4 cycles -> Status=32'h0040_0000 and Count=2.
- mtc0 Compare=5, Count=0, IM[7]=1, IE=1 -> TI set the cycle after Count==5, int_pending=1; mtc0 Compare=9 -> TI=0 the next cycle.
- exc_valid, exc_bd=1, exc_pc=32'hBFC0_1004, code 4, badv 32'h1 -> EPC=32'hBFC0_1000, BD=1, EXL=1, BadVAddr=1, redirect_pc=32'hBFC0_0380.
- Second exception while EXL=1, exc_pc=32'h8000_0000 -> EPC unchanged, ExcCode updated.
- eret with EPC=32'h8000_0100 -> cp0_flush=1, redirect_pc=32'h8000_0100, EXL=0 next cycle.
- exc_valid together with mtc0 Status=0 -> mtc0 dropped, EXL=1; reset asserted mid-run -> all registers at reset values immediately.
